// File: rtl/send_ctrl_mb_if.sv
// Bus between the send controller, the N-way acquisition buffer bank and the
// transmit serialiser. The master modport is the controller side.
interface send_ctrl_mb_if #(
  parameter int NBUF = 2,
  parameter int MAXW = 1024,
  parameter int SELW = (NBUF > 1) ? $clog2(NBUF) : 1,
  parameter int CW   = $clog2(MAXW + 1)
);
  logic            cont;
  logic            daq;
  logic            comple;
  logic [SELW-1:0] wr_sel;
  logic            ready;
  logic [NBUF-1:0] empty;
  logic [NBUF-1:0] load;
  logic [SELW-1:0] sel;
  logic            busy;
  logic            done;
  logic [CW-1:0]   word_cnt;
  logic            trunc;
  logic            err;
  logic            miss;
  logic [3:0]      dbg_state;

  // Handshake: ready is a level from the serialiser. A word moves in every
  // cycle where load[sel] is high; load is raised only after ready was high in
  // the previous cycle, never on two consecutive cycles, and the serialiser
  // must accept it. empty[sel] must reflect the read one cycle after load.
  modport master (
    input  cont, daq, comple, wr_sel, ready, empty,
    output load, sel, busy, done, word_cnt, trunc, err, miss, dbg_state
  );

  modport slave (
    output cont, daq, comple, wr_sel, ready, empty,
    input  load, sel, busy, done, word_cnt, trunc, err, miss, dbg_state
  );
endinterface

// File: rtl/send_ctrl_mb.sv
// Multi-buffer send controller: after a trigger and an acquisition-complete
// strobe, drains the just-filled buffer into the serialiser one word per load.
module send_ctrl_mb #(
  parameter int NBUF = 2,
  parameter int MAXW = 1024,
  parameter int TMO  = 4096,
  parameter int SELW = (NBUF > 1) ? $clog2(NBUF) : 1,
  parameter int CW   = $clog2(MAXW + 1)
) (
  input logic            clk,
  input logic            rst,
  send_ctrl_mb_if.master bus
);
  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_ARMED = 4'b0010,
    S_DRAIN = 4'b0100,
    S_DONE  = 4'b1000
  } state_t;

  localparam int TW     = (TMO > 1) ? $clog2(TMO) : 1;
  localparam int TMO_M1 = (TMO > 0) ? TMO - 1 : 0;
  localparam int NPOW   = 2 ** SELW;
  localparam int SW1    = SELW + 1;

  state_t          state_q;
  logic [NBUF-1:0] load_q;
  logic [SELW-1:0] sel_q;
  logic [CW-1:0]   cnt_q;
  logic [TW-1:0]   stall_q;
  logic            busy_q;
  logic            done_q;
  logic            trunc_q;
  logic            err_q;
  logic            miss_q;
  logic            trunc_pend_q;

  logic [NPOW-1:0] empty_ext;
  logic            sel_empty;
  logic            at_max;
  logic            load_low;
  logic            drain_exit;
  logic            drain_load;
  logic            stall_hit;
  logic            wr_sel_ok;

  assign empty_ext  = NPOW'(bus.empty);
  assign sel_empty  = empty_ext[sel_q];
  assign at_max     = (cnt_q == CW'(MAXW));
  assign load_low   = (load_q == '0);
  // Exits and new loads are only decided in cycles after a load-low cycle,
  // which gives the buffer one cycle to update empty after a read.
  assign drain_exit = load_low && (sel_empty || at_max);
  assign drain_load = load_low && !sel_empty && !at_max && bus.ready;
  assign stall_hit  = (TMO != 0) && (stall_q == TW'(TMO_M1));
  assign wr_sel_ok  = ({1'b0, bus.wr_sel} < SW1'(NBUF));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      load_q       <= '0;
      sel_q        <= '0;
      cnt_q        <= '0;
      stall_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      trunc_q      <= 1'b0;
      err_q        <= 1'b0;
      miss_q       <= 1'b0;
      trunc_pend_q <= 1'b0;
    end else begin
      load_q  <= '0;
      done_q  <= 1'b0;
      trunc_q <= 1'b0;
      err_q   <= 1'b0;
      miss_q  <= bus.daq && (state_q != S_IDLE);
      case (state_q)
        S_IDLE: begin
          if (bus.daq) begin
            state_q <= S_ARMED;
            busy_q  <= 1'b1;
          end
        end
        S_ARMED: begin
          if (bus.comple) begin
            state_q      <= S_DRAIN;
            sel_q        <= wr_sel_ok ? bus.wr_sel : '0;
            cnt_q        <= '0;
            stall_q      <= '0;
            trunc_pend_q <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (drain_exit) begin
            state_q      <= S_DONE;
            trunc_pend_q <= !sel_empty;
          end else if (drain_load) begin
            load_q  <= NBUF'(1) << sel_q;
            cnt_q   <= cnt_q + 1'b1;
            stall_q <= '0;
          end else if (stall_hit) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
            stall_q <= '0;
          end else begin
            stall_q <= stall_q + 1'b1;
          end
        end
        S_DONE: begin
          // trunc is held back so it pulses together with done.
          done_q  <= 1'b1;
          trunc_q <= trunc_pend_q;
          busy_q  <= bus.cont;
          state_q <= bus.cont ? S_ARMED : S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.load      = load_q;
  assign bus.sel       = sel_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.word_cnt  = cnt_q;
  assign bus.trunc     = trunc_q;
  assign bus.err       = err_q;
  assign bus.miss      = miss_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_send_ctrl_mb.sv
// Bench for send_ctrl_mb: a buffer-bank model feeds empty flags, directed
// frames check exact cycle timing, random frames check per-frame totals.
module tb_send_ctrl_mb;
  localparam int NBUF = 3;
  localparam int MAXW = 4;
  localparam int TMO  = 8;
  localparam int SELW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  send_ctrl_mb_if #(.NBUF(NBUF), .MAXW(MAXW)) bus ();

  send_ctrl_mb #(.NBUF(NBUF), .MAXW(MAXW), .TMO(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // Buffer bank model: words written minus words read per buffer.
  int   wr_tot [NBUF];
  int   ld_cnt [NBUF];
  int   done_cnt   = 0;
  int   err_cnt    = 0;
  int   miss_cnt   = 0;
  int   back2back  = 0;
  int   bad_onehot = 0;
  logic last_trunc = 1'b0;
  logic [NBUF-1:0] prev_load = '0;

  logic dir_ready;
  logic rnd_mode;
  logic rnd_ready = 1'b1;
  int   low_run   = 0;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  assign bus.ready = rnd_mode ? rnd_ready : dir_ready;

  always_comb begin
    for (int i = 0; i < NBUF; i++) bus.empty[i] = ((wr_tot[i] - ld_cnt[i]) <= 0);
  end

  always @(negedge clk) begin
    for (int i = 0; i < NBUF; i++) if (bus.load[i]) ld_cnt[i]++;
    if (bus.load != '0 && prev_load != '0) back2back++;
    if ($countones(bus.load) > 1) bad_onehot++;
    prev_load = bus.load;
    if (bus.done) begin
      done_cnt++;
      last_trunc = bus.trunc;
    end
    if (bus.err) err_cnt++;
    if (bus.miss) miss_cnt++;
  end

  // Random ready with low runs capped at 4 cycles, well inside the timeout.
  always @(negedge clk) begin
    if (low_run >= 4 || $urandom_range(0, 2) != 0) begin
      rnd_ready = 1'b1;
      low_run   = 0;
    end else begin
      rnd_ready = 1'b0;
      low_run   = low_run + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [NBUF-1:0] onehot(input int b);
    logic [NBUF-1:0] v;
    v    = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  task automatic arm();
    bus.daq = 1'b1;
    tick();
    bus.daq = 1'b0;
    chk("arm_busy", bus.busy, 1);
  endtask

  // Directed frame with ready held high, starting in ARMED. Expected timing
  // follows from the frame length: loads on even offsets, done at 2k+3.
  task automatic frame_exact(input int wsel, input int n, input logic c, input int miss_off);
    int b, k, last;
    b    = (wsel < NBUF) ? wsel : 0;
    k    = (n < MAXW) ? n : MAXW;
    last = 2 * k + 3;
    wr_tot[b]  = ld_cnt[b] + n;
    bus.cont   = c;
    bus.comple = 1'b1;
    bus.wr_sel = SELW'(wsel);
    for (int off = 1; off <= last; off++) begin
      tick();
      bus.comple = 1'b0;
      bus.daq    = (off == miss_off);
      chk("load", bus.load, (off % 2 == 0 && off <= 2 * k) ? 32'(onehot(b)) : 32'd0);
      chk("done", bus.done, off == last);
      chk("trunc", bus.trunc, (off == last) && (n > MAXW));
      chk("busy", bus.busy, (off < last) || c);
      chk("miss", bus.miss, (miss_off != 0) && (off == miss_off + 1));
    end
    bus.daq = 1'b0;
    chk("word_cnt", bus.word_cnt, k);
    chk("sel", bus.sel, b);
    chk("left", wr_tot[b] - ld_cnt[b], n - k);
  endtask

  // Random-ready frame checked on totals only.
  task automatic frame_rand(input int wsel, input int n, input logic c);
    int b, k, d0, waited;
    int ld0 [NBUF];
    b  = (wsel < NBUF) ? wsel : 0;
    k  = (n < MAXW) ? n : MAXW;
    d0 = done_cnt;
    for (int i = 0; i < NBUF; i++) ld0[i] = ld_cnt[i];
    wr_tot[b]  = ld_cnt[b] + n;
    bus.cont   = c;
    bus.comple = 1'b1;
    bus.wr_sel = SELW'(wsel);
    tick();
    bus.comple = 1'b0;
    waited = 0;
    while (done_cnt == d0 && waited < 200) begin
      tick();
      waited++;
    end
    chk("rnd_done", done_cnt - d0, 1);
    for (int i = 0; i < NBUF; i++) chk("rnd_loads", ld_cnt[i] - ld0[i], (i == b) ? k : 0);
    chk("rnd_word_cnt", bus.word_cnt, k);
    chk("rnd_trunc", last_trunc, n > MAXW);
    chk("rnd_busy", bus.busy, c);
    chk("rnd_left", wr_tot[b] - ld_cnt[b], n - k);
  endtask

  initial begin
    int   d0, s0;
    logic armed;
    rnd_mode   = 1'b0;
    dir_ready  = 1'b1;
    bus.cont   = 1'b0;
    bus.daq    = 1'b0;
    bus.comple = 1'b0;
    bus.wr_sel = '0;
    for (int i = 0; i < NBUF; i++) begin
      wr_tot[i] = 0;
      ld_cnt[i] = 0;
    end
    rst = 1'b1;
    repeat (2) tick();
    chk("rst_load", bus.load, 0);
    chk("rst_sel", bus.sel, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_word_cnt", bus.word_cnt, 0);
    chk("rst_flags", {bus.trunc, bus.err, bus.miss}, 0);
    rst = 1'b0;
    tick();

    // Three words from buffer 1; buffer 0 never touched.
    arm();
    frame_exact(1, 3, 1'b0, 0);
    chk("ld0_untouched", ld_cnt[0], 0);

    // Ten words in buffer 2 truncated at MAXW.
    arm();
    frame_exact(2, 10, 1'b0, 0);
    wr_tot[2] = ld_cnt[2];

    // daq during DRAIN reports miss, frame unaffected.
    arm();
    frame_exact(0, 3, 1'b0, 3);

    // daq and comple together in IDLE only arm.
    wr_tot[1]  = ld_cnt[1] + 2;
    s0         = ld_cnt[1];
    bus.daq    = 1'b1;
    bus.comple = 1'b1;
    bus.wr_sel = 2'd1;
    tick();
    bus.daq    = 1'b0;
    bus.comple = 1'b0;
    chk("dc_busy", bus.busy, 1);
    tick();
    tick();
    chk("dc_noload", ld_cnt[1] - s0, 0);
    chk("dc_word_cnt_hold", bus.word_cnt, 3);
    frame_exact(1, 2, 1'b0, 0);

    // Continuous mode: back-to-back frames, then an empty frame to leave.
    arm();
    frame_exact(0, 2, 1'b1, 0);
    frame_exact(1, 2, 1'b1, 0);
    frame_exact(2, 0, 1'b0, 0);

    // Out-of-range wr_sel falls back to buffer 0.
    arm();
    frame_exact(3, 2, 1'b0, 0);

    // Timeout after the first load.
    d0        = done_cnt;
    wr_tot[0] = ld_cnt[0] + 5;
    arm();
    bus.comple = 1'b1;
    bus.wr_sel = 2'd0;
    for (int off = 1; off <= 11; off++) begin
      tick();
      bus.comple = 1'b0;
      if (off == 2) dir_ready = 1'b0;
      chk("tmo_load", bus.load, (off == 2) ? 32'd1 : 32'd0);
      chk("tmo_err", bus.err, off == 10);
    end
    chk("tmo_busy", bus.busy, 0);
    chk("tmo_nodone", done_cnt - d0, 0);
    chk("tmo_left", wr_tot[0] - ld_cnt[0], 4);
    wr_tot[0] = ld_cnt[0];

    // Timeout with no load at all, counted from DRAIN entry.
    wr_tot[1] = ld_cnt[1] + 2;
    arm();
    bus.comple = 1'b1;
    bus.wr_sel = 2'd1;
    for (int off = 1; off <= 10; off++) begin
      tick();
      bus.comple = 1'b0;
      chk("tmo0_load", bus.load, 0);
      chk("tmo0_err", bus.err, off == 9);
    end
    chk("tmo0_nodone", done_cnt - d0, 0);
    wr_tot[1] = ld_cnt[1];
    dir_ready = 1'b1;

    // Asynchronous reset while load is high.
    wr_tot[2] = ld_cnt[2] + 3;
    s0        = ld_cnt[2];
    arm();
    bus.comple = 1'b1;
    bus.wr_sel = 2'd2;
    tick();
    bus.comple = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_rst_load", bus.load, 3'b100);
    rst = 1'b1;
    #1;
    chk("arst_load", bus.load, 0);
    chk("arst_sel", bus.sel, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_word_cnt", bus.word_cnt, 0);
    chk("arst_flags", {bus.done, bus.trunc, bus.err, bus.miss}, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("arst_noread", ld_cnt[2] - s0, 0);
    arm();
    frame_exact(2, 3, 1'b0, 0);

    // Random frames with random ready.
    rnd_mode = 1'b1;
    armed    = 1'b0;
    for (int f = 0; f < 24; f++) begin
      int   wsel, n;
      logic c;
      wsel = $urandom_range(0, 3);
      n    = $urandom_range(0, 7);
      c    = 1'($urandom_range(0, 1));
      if (!armed) arm();
      frame_rand(wsel, n, c);
      armed = c;
    end
    if (armed) frame_rand(0, 0, 1'b0);
    rnd_mode = 1'b0;

    chk("no_back2back", back2back, 0);
    chk("onehot", bad_onehot, 0);
    chk("err_total", err_cnt, 2);
    chk("miss_total", miss_cnt, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
